// File: rtl/full_adder_pkg.sv
// Shared constants for the adder family; currently only the default operand width.
package full_adder_pkg;

  localparam int unsigned FA_DEFAULT_WIDTH = 1;

endpackage : full_adder_pkg

// File: rtl/full_adder_fa_cell.sv
// One-bit full-adder cell: the ripple element of full_adder.
module fa_cell
  import full_adder_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule : fa_cell

// File: rtl/full_adder.sv
// Parameterised ripple-carry adder with a combinational result and a
// one-cycle registered copy qualified by in_valid.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] s_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             out_valid
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] r_s_q;
  logic             r_cout_q;
  logic             r_ovf_q;
  logic             r_out_valid;

  assign w_carry[0] = cin;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    fa_cell u_cell (
      .x    (x[g]),
      .y    (y[g]),
      .cin  (w_carry[g]),
      .s    (s[g]),
      .cout (w_carry[g+1])
    );
  end

  assign cout = w_carry[WIDTH];
  // Carry into the MSB versus carry out of it; for WIDTH=1 this is cin ^ cout.
  assign ovf  = w_carry[WIDTH-1] ^ w_carry[WIDTH];

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_q       <= '0;
      r_cout_q    <= 1'b0;
      r_ovf_q     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_s_q    <= s;
        r_cout_q <= cout;
        r_ovf_q  <= ovf;
      end
    end
  end

  assign s_q       = r_s_q;
  assign cout_q    = r_cout_q;
  assign ovf_q     = r_ovf_q;
  assign out_valid = r_out_valid;

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Self-checking bench: three widths of full_adder against an arithmetic reference.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n;

  logic        x1, y1, cin1, v1;
  logic        s1, cout1, ovf1, s1_q, cout1_q, ovf1_q, ov1;
  logic [7:0]  x8, y8, s8, s8_q;
  logic        cin8, v8, cout8, ovf8, cout8_q, ovf8_q, ov8;
  logic [15:0] x16, y16, s16, s16_q;
  logic        cin16, v16, cout16, ovf16, cout16_q, ovf16_q, ov16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .x(x1), .y(y1), .cin(cin1), .in_valid(v1),
    .s(s1), .cout(cout1), .ovf(ovf1),
    .s_q(s1_q), .cout_q(cout1_q), .ovf_q(ovf1_q), .out_valid(ov1)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .x(x8), .y(y8), .cin(cin8), .in_valid(v8),
    .s(s8), .cout(cout8), .ovf(ovf8),
    .s_q(s8_q), .cout_q(cout8_q), .ovf_q(ovf8_q), .out_valid(ov8)
  );

  full_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .x(x16), .y(y16), .cin(cin16), .in_valid(v16),
    .s(s16), .cout(cout16), .ovf(ovf16),
    .s_q(s16_q), .cout_q(cout16_q), .ovf_q(ovf16_q), .out_valid(ov16)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: {cout,s} as the plain unsigned sum in WIDTH+1 bits.
  function automatic int unsigned ref_sum(int w, int unsigned a, int unsigned b, int unsigned c);
    return (a + b + c) & ((1 << (w + 1)) - 1);
  endfunction

  // Reference: signed overflow when the two's-complement sum leaves the WIDTH-bit range.
  function automatic int unsigned ref_ovf(int w, int unsigned a, int unsigned b, int unsigned c);
    int sa, sb, total;
    sa = (a >= (1 << (w - 1))) ? int'(a) - (1 << w) : int'(a);
    sb = (b >= (1 << (w - 1))) ? int'(b) - (1 << w) : int'(b);
    total = sa + sb + int'(c);
    return (total > (1 << (w - 1)) - 1 || total < -(1 << (w - 1))) ? 1 : 0;
  endfunction

  task automatic check8_comb(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
    x8 = a; y8 = b; cin8 = c;
    #1;
    check({tag, "_sum"}, {23'd0, cout8, s8}, ref_sum(8, a, b, c));
    check({tag, "_ovf"}, {31'd0, ovf8}, ref_ovf(8, a, b, c));
  endtask

  initial begin
    logic [15:0] ex_sum;
    logic [16:0] exp_q;
    logic        exp_ovf;
    logic [8:0]  lit;

    rst_n = 1'b0;
    x1 = 0; y1 = 0; cin1 = 0; v1 = 0;
    x8 = 0; y8 = 0; cin8 = 0; v8 = 0;
    x16 = 0; y16 = 0; cin16 = 0; v16 = 0;
    #7;
    check("rst_valid1", {31'd0, ov1}, 0);
    check("rst_q8", {22'd0, ovf8_q, cout8_q, s8_q}, 0);
    check("rst_valid16", {31'd0, ov16}, 0);

    // 1-bit truth table, exercised while still in reset
    for (int i = 0; i < 8; i++) begin
      {x1, y1, cin1} = 3'(i);
      #100;
      check($sformatf("w1_sum_%0d", i), {30'd0, cout1, s1}, ref_sum(1, x1, y1, cin1));
      check($sformatf("w1_ovf_%0d", i), {31'd0, ovf1}, {31'd0, cin1 ^ cout1});
    end

    // 8-bit boundary cases
    check8_comb("ff_01_0", 8'hFF, 8'h01, 1'b0);
    check8_comb("ff_01_1", 8'hFF, 8'h01, 1'b1);
    check8_comb("7f_01_0", 8'h7F, 8'h01, 1'b0);
    check8_comb("80_80_0", 8'h80, 8'h80, 1'b0);
    check8_comb("ff_ff_1", 8'hFF, 8'hFF, 1'b1);
    x8 = 8'h7F; y8 = 8'h01; cin8 = 1'b0; #1;
    lit = {cout8, s8};
    check("lit_7f01", {23'd0, lit}, 32'h080);
    check("lit_7f01_ovf", {31'd0, ovf8}, 1);
    for (int i = 0; i < 20; i++)
      check8_comb("rnd8", 8'($urandom), 8'($urandom), 1'($urandom));

    // Release; first cycle without in_valid must not produce a result
    @(negedge clk);
    rst_n = 1'b1;
    v8 = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", {31'd0, ov8}, 0);
    check("post_rst_sq", {24'd0, s8_q}, 0);

    // Single-cycle capture then hold
    @(negedge clk);
    x8 = 8'h12; y8 = 8'h34; cin8 = 1'b1; v8 = 1'b1;
    @(posedge clk); #1;
    check("cap_sq", {24'd0, s8_q}, 32'h47);
    check("cap_cout", {31'd0, cout8_q}, 0);
    check("cap_ovf", {31'd0, ovf8_q}, 0);
    check("cap_valid", {31'd0, ov8}, 1);
    @(negedge clk);
    v8 = 1'b0; x8 = 8'hF0; y8 = 8'hF0; cin8 = 1'b1;
    @(posedge clk); #1;
    check("hold_valid", {31'd0, ov8}, 0);
    check("hold_sq", {24'd0, s8_q}, 32'h47);
    check("hold_cout", {31'd0, cout8_q}, 0);

    // Asynchronous reset between edges while a result is held
    @(negedge clk);
    x8 = 8'h80; y8 = 8'h80; cin8 = 1'b0; v8 = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_valid", {31'd0, ov8}, 1);
    check("pre_rst_q", {22'd0, ovf8_q, cout8_q, s8_q}, {22'd0, 1'b1, 1'b1, 8'h00});
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_q", {22'd0, ovf8_q, cout8_q, s8_q}, 0);
    check("arst_valid", {31'd0, ov8}, 0);
    x8 = 8'h3C; y8 = 8'h0F; cin8 = 1'b1;
    #1;
    check("arst_comb", {23'd0, cout8, s8}, ref_sum(8, 8'h3C, 8'h0F, 1));
    @(negedge clk);
    v8 = 1'b0;
    rst_n = 1'b1;

    // 16-bit random stream, one operand per cycle
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      x16 = 16'($urandom); y16 = 16'($urandom); cin16 = 1'($urandom); v16 = 1'b1;
      exp_q   = 17'(ref_sum(16, x16, y16, cin16));
      exp_ovf = 1'(ref_ovf(16, x16, y16, cin16));
      ex_sum  = exp_q[15:0];
      @(posedge clk); #1;
      check("s16_q", {15'd0, cout16_q, s16_q}, {15'd0, exp_q[16], ex_sum});
      check("ovf16_q", {31'd0, ovf16_q}, {31'd0, exp_ovf});
      check("valid16", {31'd0, ov16}, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_full_adder
